// File: rtl/cordic_rotation_scheduler.sv
// cordic_rotation_scheduler: round-robin front end that shares one iterative CORDIC
// rotation unit between NREQ requesters. It latches the winner's operands, holds
// cor_valid until cor_done, and returns the result pair tagged with the requester index.
// Optional build macro: CORDIC_SCHED_TIMEOUT_EN adds an abort after TIMEOUT RUN cycles.
module cordic_rotation_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WL      = 16,
  parameter int unsigned TIMEOUT = 31,
  localparam int unsigned IDW    = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*WL-1:0] req_x,
  input  logic [NREQ*WL-1:0] req_y,
  input  logic [NREQ*WL-1:0] req_theta,
  output logic [NREQ-1:0]    gnt,
  output logic               cor_valid,
  output logic [WL-1:0]      cor_x,
  output logic [WL-1:0]      cor_y,
  output logic [WL-1:0]      cor_theta,
  input  logic [WL-1:0]      cor_x_res,
  input  logic [WL-1:0]      cor_y_res,
  input  logic               cor_done,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WL-1:0]      res_x,
  output logic [WL-1:0]      res_y,
  output logic [IDW-1:0]     res_id,
  output logic               res_err,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StRun, StResult} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [WL-1:0]  op_x_q, op_x_d;
  logic [WL-1:0]  op_y_q, op_y_d;
  logic [WL-1:0]  op_t_q, op_t_d;
  logic [WL-1:0]  rx_q, rx_d;
  logic [WL-1:0]  ry_q, ry_d;
  logic           err_q, err_d;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] cand;
  logic [WL-1:0]  win_x, win_y, win_t;
  logic           tmo_hit;

  if (NREQ < 2 || TIMEOUT < 1) begin : g_param_check
    $error("cordic_rotation_scheduler: NREQ must be >= 2 and TIMEOUT >= 1");
  end

  // Round-robin pick: first requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(ptr_q) + i) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    win_x = '0;
    win_y = '0;
    win_t = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        win_x = req_x[i*WL +: WL];
        win_y = req_y[i*WL +: WL];
        win_t = req_theta[i*WL +: WL];
      end
    end
  end

`ifdef CORDIC_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;

  // The counter is zero on RUN entry; it fires in the TIMEOUT-th RUN cycle.
  assign tmo_hit = (state_q == StRun) && (tmo_cnt_q == CntW'(TIMEOUT - 1));

  // Timeout counter next state: count RUN cycles, clear everywhere else.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == StRun) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // FSM next state plus the datapath registers it controls.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    gnt_d   = '0;
    op_x_d  = op_x_q;
    op_y_d  = op_y_q;
    op_t_d  = op_t_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StRun;
          ptr_d   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          id_d    = win_idx;
          gnt_d   = NREQ'(1) << win_idx;
          op_x_d  = win_x;
          op_y_d  = win_y;
          op_t_d  = win_t;
        end
      end
      StRun: begin
        // A real done beats a timeout landing on the same edge.
        if (cor_done) begin
          state_d = StResult;
          rx_d    = cor_x_res;
          ry_d    = cor_y_res;
          err_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d = StResult;
          rx_d    = '0;
          ry_d    = '0;
          err_d   = 1'b1;
        end
      end
      StResult: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset clears every output and the RR pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      op_x_q  <= '0;
      op_y_q  <= '0;
      op_t_q  <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      op_x_q  <= op_x_d;
      op_y_q  <= op_y_d;
      op_t_q  <= op_t_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      err_q   <= err_d;
    end
  end

  // cor_valid comes straight from the state register, so an async reset drops it at once,
  // and RESULT plus the following IDLE cycle give the unit its low re-arm gap.
  assign cor_valid = (state_q == StRun);
  assign res_valid = (state_q == StResult);
  assign busy      = (state_q != StIdle);
  assign gnt       = gnt_q;
  assign cor_x     = op_x_q;
  assign cor_y     = op_y_q;
  assign cor_theta = op_t_q;
  assign res_x     = rx_q;
  assign res_y     = ry_q;
  assign res_id    = id_q;
`ifdef CORDIC_SCHED_TIMEOUT_EN
  assign res_err   = err_q;
`else
  assign res_err   = err_q & 1'b0;
`endif

endmodule
